// File: rtl/vending_change_fsm_if.sv
// Coin/cancel request and vend/change response bundle
// for the vending change FSM.
interface vending_change_fsm_if #(
  parameter int CREDIT_W = 5
);
  logic                in1;
  logic                in2;
  logic                in5;
  logic                cancel;
  logic                vend;
  logic                out1;
  logic                out2;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output in1, in2, in5, cancel,
    input  vend, out1, out2, credit, busy
  );

  modport slave (
    input  in1, in2, in5, cancel,
    output vend, out1, out2, credit, busy
  );
endinterface

// File: rtl/vending_change_fsm.sv
// Coin-collecting vending FSM with automatic change return.
// Define VEND_MULTI_SALE_EN to carry residual credit over instead.
module vending_change_fsm #(
  parameter int PRICE    = 7,
  parameter int CREDIT_W = 5
) (
  input  logic clk,
  input  logic rst,
  vending_change_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] PRICE_W = SW'(PRICE);
  localparam logic [SW-1:0] C1 = SW'(1);
  localparam logic [SW-1:0] C2 = SW'(2);
  localparam logic [SW-1:0] C5 = SW'(5);

  state_t              state_q;
  state_t              state_d;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic [SW-1:0]       coin;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       rest;

  // State and credit registers; reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  // Coin select, next state and next credit.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    priority case (1'b1)
      bus.in5: coin = C5;
      bus.in2: coin = C2;
      bus.in1: coin = C1;
      default: coin = '0;
    endcase
    sum  = {1'b0, credit_q} + coin;
    rest = sum - PRICE_W;
    case (state_q)
      COLLECT: begin
        if (bus.cancel) begin
          if (credit_q != '0) state_d = CHANGE;
        end else if (coin != '0) begin
          if (sum >= PRICE_W) begin
            credit_d = rest[CREDIT_W-1:0];
            state_d  = VEND;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
`ifdef VEND_MULTI_SALE_EN
        state_d = COLLECT;
`else
        state_d = (credit_q != '0) ? CHANGE : COLLECT;
`endif
      end
      CHANGE: begin
        if (credit_q >= CREDIT_W'(2))
          credit_d = credit_q - CREDIT_W'(2);
        else
          credit_d = credit_q - CREDIT_W'(1);
        if (credit_d == '0) state_d = COLLECT;
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  // Outputs decoded from registered state and credit only.
  always_comb begin
    bus.vend   = (state_q == VEND);
    bus.busy   = (state_q != COLLECT);
    bus.out2   = (state_q == CHANGE) && (credit_q >= CREDIT_W'(2));
    bus.out1   = (state_q == CHANGE) && (credit_q == CREDIT_W'(1));
    bus.credit = credit_q;
  end

endmodule
